fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 91 +++++++++
 tb/tb_fetch_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, a single-entry output
// buffer toward decode, and redirect handling that discards stale responses.
module fetch_stage #(
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [ADDR_WIDTH-1:0]  imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_resp_data,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0]  out_pc
);

    localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [ADDR_WIDTH-1:0]  r_pc;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [ADDR_WIDTH-1:0]  r_out_pc;
    logic                   w_accept;
    logic                   w_capture;

    assign w_accept  = imem_req_valid & imem_req_ready;
    assign w_capture = (r_state == S_WAIT) & imem_resp_valid & ~redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_REQ;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_REQ: begin
                // An accepted request abandoned by a redirect still owes us a response.
                if (redirect_valid) w_next = w_accept ? S_DROP : S_REQ;
                else if (w_accept)  w_next = S_WAIT;
            end
            S_WAIT: begin
                if (redirect_valid)       w_next = imem_resp_valid ? S_REQ : S_DROP;
                else if (imem_resp_valid) w_next = S_HOLD;
            end
            S_HOLD: begin
                if (redirect_valid || out_ready) w_next = S_REQ;
            end
            S_DROP: begin
                // A redirect only retargets pc here; the stale response still ends the drop.
                if (imem_resp_valid) w_next = S_REQ;
            end
            default: w_next = S_REQ;
        endcase
    end

    always_comb begin
        imem_req_valid = (r_state == S_REQ) & ~rst;
        imem_req_addr  = r_pc;
        out_valid      = (r_state == S_HOLD);
        out_instr      = out_valid ? r_instr : NOP;
        out_pc         = r_out_pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_instr  <= NOP;
            r_out_pc <= '0;
        end else begin
            if (redirect_valid)
                r_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            else if (r_state == S_HOLD && out_ready)
                r_pc <= r_pc + ADDR_WIDTH'(4);
            if (w_capture) begin
                r_instr  <= imem_resp_data;
                r_out_pc <= r_pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, request/output backpressure,
// redirects in every state, pc wrap and asynchronous reset mid-transaction.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_stage #(.INSTR_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory contents: each word tags its own address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    // One full request/response/hand-off with everything ready.
    task automatic do_fetch(input logic [31:0] addr);
        chk("req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("req_addr", imem_req_addr, addr);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("wait_out_instr", out_instr, NOP);
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem(addr);
        tick();
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'hDEAD_BEEF;
        chk("hold_valid", {31'b0, out_valid}, 32'd1);
        chk("hold_instr", out_instr, mem(addr));
        chk("hold_pc", out_pc, addr);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, NOP);
        chk("rst_out_pc", out_pc, 32'h0);
        rst = 1'b0;
        #1;

        // Sequential fetch with a 3-cycle request stall at 0x4.
        do_fetch(32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd1);
            chk("stall_req_addr", imem_req_addr, 32'h4);
            tick();
        end
        do_fetch(32'h4);
        do_fetch(32'h8);

        // Output backpressure in HOLD at 0xC.
        chk("bp_req_addr", imem_req_addr, 32'hC);
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = mem(32'hC); tick(); imem_resp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_instr", out_instr, 32'hC0DE_000C);
            chk("bp_pc", out_pc, 32'hC);
            chk("bp_req_valid", {31'b0, imem_req_valid}, 32'd0);
            tick();
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("bp_next_addr", imem_req_addr, 32'h10);

        // Response while in REQ is ignored.
        imem_resp_valid = 1'b1; imem_resp_data = 32'h1111_1111; tick(); imem_resp_valid = 1'b0;
        chk("ign_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("ign_req_addr", imem_req_addr, 32'h10);
        chk("ign_out_valid", {31'b0, out_valid}, 32'd0);

        // Redirect in WAIT: stale response dropped, target aligned.
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h103; tick(); redirect_valid = 1'b0;
        chk("drop_req_valid", {31'b0, imem_req_valid}, 32'd0);
        imem_resp_valid = 1'b1; imem_resp_data = mem(32'h10); tick(); imem_resp_valid = 1'b0;
        chk("drop_out_valid", {31'b0, out_valid}, 32'd0);
        chk("drop_out_instr", out_instr, NOP);
        do_fetch(32'h100);

        // Redirect coincident with a response in WAIT.
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        imem_resp_valid = 1'b1; imem_resp_data = mem(32'h104);
        tick();
        redirect_valid = 1'b0; imem_resp_valid = 1'b0;
        chk("wr_out_valid", {31'b0, out_valid}, 32'd0);
        chk("wr_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("wr_req_addr", imem_req_addr, 32'h200);
        do_fetch(32'h200);

        // Redirect coincident with out_ready in HOLD kills the held word.
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = mem(32'h204); tick(); imem_resp_valid = 1'b0;
        chk("hr_held_valid", {31'b0, out_valid}, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h300; out_ready = 1'b1;
        tick();
        redirect_valid = 1'b0; out_ready = 1'b0;
        chk("hr_out_valid", {31'b0, out_valid}, 32'd0);
        chk("hr_out_instr", out_instr, NOP);
        chk("hr_req_addr", imem_req_addr, 32'h300);
        do_fetch(32'h300);

        // Redirect on the accept cycle, then again while dropping.
        imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h400;
        tick();
        imem_req_ready = 1'b0;
        chk("ra_req_valid", {31'b0, imem_req_valid}, 32'd0);
        redirect_pc = 32'h500; tick(); redirect_valid = 1'b0;
        chk("dd_req_valid", {31'b0, imem_req_valid}, 32'd0);
        imem_resp_valid = 1'b1; imem_resp_data = mem(32'h304); tick(); imem_resp_valid = 1'b0;
        chk("dd_out_valid", {31'b0, out_valid}, 32'd0);
        chk("dd_req_addr", imem_req_addr, 32'h500);

        // Redirect in REQ without acceptance, to the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; tick(); redirect_valid = 1'b0;
        do_fetch(32'hFFFF_FFFC);
        do_fetch(32'h0000_0000);

        // Asynchronous reset while in WAIT.
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("arst_req_addr", imem_req_addr, 32'h0);
        chk("arst_req_valid2", {31'b0, imem_req_valid}, 32'd1);
        imem_resp_valid = 1'b1; imem_resp_data = mem(32'h4); tick(); imem_resp_valid = 1'b0;
        chk("arst_ign_valid", {31'b0, out_valid}, 32'd0);
        do_fetch(32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
